// File: rtl/key_evt_pkg.sv
// Shared constants and types for the key event arbiter: default key count,
// the vending-machine key map, event-code width and output register states.
package key_evt_pkg;

    localparam int NUM_KEYS_DEF = 6;

    // Key map of the micro-vending-machine front panel.
    localparam int KEY_COIN1   = 0;
    localparam int KEY_COIN5   = 1;
    localparam int KEY_COIN10  = 2;
    localparam int KEY_SEL     = 3;
    localparam int KEY_CONFIRM = 4;
    localparam int KEY_CANCEL  = 5;

    // Width of an event code able to name any of n keys (at least one bit).
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int IDX_W_DEF = idx_width(NUM_KEYS_DEF);

    // Output register occupancy.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/key_rr_pick.sv
// Combinational round-robin picker: finds the first set pending bit at or
// above rr_ptr, wrapping modulo NUM_KEYS. rr_ptr is always < NUM_KEYS.
module key_rr_pick #(
    parameter int NUM_KEYS = 6,
    parameter int IDX_W    = 3
) (
    input  logic [NUM_KEYS-1:0] pending,
    input  logic [IDX_W-1:0]    rr_ptr,
    output logic                any,
    output logic [IDX_W-1:0]    grant
);

    int idx;

    // Scan offsets from the far end down so the smallest offset wins.
    always_comb begin
        any   = |pending;
        grant = '0;
        idx   = 0;
        for (int j = NUM_KEYS - 1; j >= 0; j--) begin
            idx = int'(rr_ptr) + j;
            if (idx >= NUM_KEYS) begin
                idx = idx - NUM_KEYS;
            end
            if (pending[idx]) begin
                grant = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/key_event_arbiter.sv
// Serialises single-cycle key presses into one valid/ready event stream.
// Each key owns a sticky pending bit; pending keys are served round-robin,
// the cancel key pre-empts and flushes the others, and a press landing on a
// key that is still pending (and not being granted) is dropped and flagged
// in the sticky overrun vector.
//
// Handshake: evt_valid/evt_code form a registered source. A transfer happens
// on a rising edge where evt_valid && evt_ready. Once evt_valid is high it
// stays high and evt_code stays stable until that transfer; a new event may
// be loaded on the same edge as the transfer, so there is no bubble.
module key_event_arbiter
    import key_evt_pkg::*;
#(
    parameter int NUM_KEYS   = NUM_KEYS_DEF,
    parameter int CANCEL_IDX = KEY_CANCEL,
    parameter int IDX_W      = idx_width(NUM_KEYS)
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [NUM_KEYS-1:0] key_pulse,
    output logic                evt_valid,
    output logic [IDX_W-1:0]    evt_code,
    input  logic                evt_ready,
    output logic [NUM_KEYS-1:0] overrun,
    input  logic                overrun_clr,
    output out_state_t          dbg_state
);

    localparam logic [NUM_KEYS-1:0] ONE_HOT0   = NUM_KEYS'(1);
    localparam logic [IDX_W-1:0]    CANCEL_CODE = IDX_W'(CANCEL_IDX);
    localparam logic [IDX_W-1:0]    LAST_CODE   = IDX_W'(NUM_KEYS - 1);

    out_state_t          state;
    out_state_t          state_nxt;
    logic [NUM_KEYS-1:0] pending;
    logic [NUM_KEYS-1:0] pending_nxt;
    logic [NUM_KEYS-1:0] overrun_nxt;
    logic [NUM_KEYS-1:0] grant_vec;
    logic [NUM_KEYS-1:0] flush_vec;
    logic [NUM_KEYS-1:0] overrun_set;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    grant_idx;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic                loadable;
    logic                do_grant;
    logic                cancel_hit;

    key_rr_pick #(
        .NUM_KEYS (NUM_KEYS),
        .IDX_W    (IDX_W)
    ) u_pick (
        .pending (pending),
        .rr_ptr  (rr_ptr),
        .any     (pick_any),
        .grant   (pick_idx)
    );

    // Grant decision, flush mask and next pending/overrun vectors.
    always_comb begin
        loadable    = (state == ST_EMPTY) || evt_ready;
        do_grant    = loadable && pick_any;
        cancel_hit  = pending[CANCEL_IDX];
        grant_idx   = cancel_hit ? CANCEL_CODE : pick_idx;
        grant_vec   = do_grant ? (ONE_HOT0 << grant_idx) : '0;
        flush_vec   = (do_grant && cancel_hit) ? ~(ONE_HOT0 << CANCEL_CODE) : '0;
        // A fresh press always survives a same-cycle grant or flush.
        pending_nxt = key_pulse | (pending & ~(grant_vec | flush_vec));
        // Being flushed is not being granted, so a flushed key can overrun.
        overrun_set = key_pulse & pending & ~grant_vec;
        overrun_nxt = overrun_clr ? overrun_set : (overrun | overrun_set);
    end

    // Pending, overrun, round-robin pointer and event code registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pending  <= '0;
            overrun  <= '0;
            rr_ptr   <= '0;
            evt_code <= '0;
        end else begin
            pending <= pending_nxt;
            overrun <= overrun_nxt;
            if (do_grant) begin
                evt_code <= grant_idx;
                rr_ptr   <= (grant_idx == LAST_CODE) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    // Output register occupancy state.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Fill on a grant; drain only when accepted with nothing to reload.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (do_grant) state_nxt = ST_FULL;
            ST_FULL:  if (evt_ready && !do_grant) state_nxt = ST_EMPTY;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    // Outputs decoded from the occupancy state.
    always_comb begin
        evt_valid = (state == ST_FULL);
        dbg_state = state;
    end

endmodule

// File: tb/tb_key_event_arbiter.sv
// Self-checking bench for key_event_arbiter: directed scenarios plus a short
// randomised stall test, with a scoreboard of expected event codes.
module tb_key_event_arbiter;
    import key_evt_pkg::*;

    localparam int N = NUM_KEYS_DEF;
    localparam int W = idx_width(N);

    logic         sys_clk = 1'b0;
    logic         sys_rst_n = 1'b0;
    logic [N-1:0] key_pulse = '0;
    logic         evt_ready = 1'b0;
    logic         overrun_clr = 1'b0;
    logic         evt_valid;
    logic [W-1:0] evt_code;
    logic [N-1:0] overrun;
    out_state_t   dbg_state;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_exp;
    int           checks = 0;
    int           errors = 0;

    always #5 sys_clk = ~sys_clk;

    key_event_arbiter dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .key_pulse   (key_pulse),
        .evt_valid   (evt_valid),
        .evt_code    (evt_code),
        .evt_ready   (evt_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .dbg_state   (dbg_state)
    );

    // Scoreboard: every accepted event must match the head of exp_q.
    always @(negedge sys_clk) begin
        if (sys_rst_n && evt_valid && evt_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event code=%0d expected none", evt_code);
            end else begin
                mon_exp = exp_q.pop_front();
                if (evt_code !== mon_exp) begin
                    errors++;
                    $display("FAIL event_code got=%0d expected=%0d", evt_code, mon_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic pulse(input logic [N-1:0] k);
        key_pulse = k;
        tick();
        key_pulse = '0;
    endtask

    task automatic do_reset();
        key_pulse   = '0;
        evt_ready   = 1'b0;
        overrun_clr = 1'b0;
        sys_rst_n   = 1'b0;
        tick();
        tick();
        exp_q.delete();
        sys_rst_n = 1'b1;
        tick();
    endtask

    // Wait (bounded) for all expected events, then confirm nothing is left.
    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        tick();
        tick();
        @(negedge sys_clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout left=%0d expected 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_idle evt_valid=%b expected 0", evt_valid);
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        #2;
        checks++;
        if (evt_valid !== 1'b0 || evt_code !== '0 || overrun !== '0 || dbg_state !== ST_EMPTY) begin
            errors++;
            $display("FAIL reset_values valid=%b code=%0d overrun=%b state=%0d expected 0/0/0/EMPTY",
                     evt_valid, evt_code, overrun, dbg_state);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        evt_ready = 1'b1;
        exp_q.push_back(W'(KEY_COIN10));
        key_pulse = 6'b000100;
        @(negedge sys_clk);
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++; $display("FAIL single_pre valid=%b expected 0", evt_valid);
        end
        tick();
        key_pulse = '0;
        @(negedge sys_clk);
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++; $display("FAIL single_k valid=%b expected 0", evt_valid);
        end
        tick();
        @(negedge sys_clk);
        checks++;
        if (evt_valid !== 1'b1 || evt_code !== W'(2)) begin
            errors++; $display("FAIL single_k1 valid=%b code=%0d expected 1/2", evt_valid, evt_code);
        end
        tick();
        @(negedge sys_clk);
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++; $display("FAIL single_k2 valid=%b expected 0", evt_valid);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        evt_ready = 1'b1;
        exp_q.push_back(W'(0));
        exp_q.push_back(W'(1));
        exp_q.push_back(W'(3));
        pulse(6'b001011);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge sys_clk);
            checks++;
            if (evt_valid !== 1'b1) begin
                errors++; $display("FAIL rr_throughput cycle=%0d valid=%b expected 1", i, evt_valid);
            end
        end
        wait_drain(10);
        // Pointer now 4: the upward search wraps past 5 and finds key 0 first.
        exp_q.push_back(W'(0));
        exp_q.push_back(W'(1));
        pulse(6'b000011);
        wait_drain(10);
    endtask

    task automatic test_cancel_flush();
        do_reset();
        exp_q.push_back(W'(1));
        pulse(6'b000010);
        tick();
        @(negedge sys_clk);
        checks++;
        if (evt_valid !== 1'b1 || evt_code !== W'(1)) begin
            errors++; $display("FAIL cancel_hold valid=%b code=%0d expected 1/1", evt_valid, evt_code);
        end
        exp_q.push_back(W'(KEY_CANCEL));
        pulse(6'b101110);
        tick();
        @(negedge sys_clk);
        checks++;
        if (evt_valid !== 1'b1 || evt_code !== W'(1)) begin
            errors++; $display("FAIL cancel_stall valid=%b code=%0d expected 1/1", evt_valid, evt_code);
        end
        evt_ready = 1'b1;
        wait_drain(10);
        checks++;
        if (overrun !== '0) begin
            errors++; $display("FAIL cancel_overrun got=%b expected 000000", overrun);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        exp_q.push_back(W'(0));
        pulse(6'b000001);
        exp_q.push_back(W'(3));
        pulse(6'b001000);
        tick();
        tick();
        pulse(6'b001000);
        @(negedge sys_clk);
        checks++;
        if (overrun !== 6'b001000) begin
            errors++; $display("FAIL overrun_set got=%b expected 001000", overrun);
        end
        evt_ready = 1'b1;
        wait_drain(10);
        checks++;
        if (overrun !== 6'b001000) begin
            errors++; $display("FAIL overrun_sticky got=%b expected 001000", overrun);
        end
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (overrun !== '0) begin
            errors++; $display("FAIL overrun_clr got=%b expected 000000", overrun);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        evt_ready = 1'b1;
        exp_q.push_back(W'(0));
        exp_q.push_back(W'(0));
        pulse(6'b000001);
        pulse(6'b000001);
        wait_drain(10);
        checks++;
        if (overrun !== '0) begin
            errors++; $display("FAIL simult_overrun got=%b expected 000000", overrun);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        exp_q.push_back(W'(0));
        pulse(6'b000001);
        pulse(6'b001110);
        pulse(6'b000010);
        @(negedge sys_clk);
        checks++;
        if (evt_valid !== 1'b1 || overrun !== 6'b000010) begin
            errors++; $display("FAIL midrst_setup valid=%b overrun=%b expected 1/000010", evt_valid, overrun);
        end
        #2;
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if (evt_valid !== 1'b0 || overrun !== '0 || evt_code !== '0) begin
            errors++; $display("FAIL midrst_async valid=%b overrun=%b code=%0d expected 0/0/0",
                               evt_valid, overrun, evt_code);
        end
        exp_q.delete();
        tick();
        tick();
        sys_rst_n = 1'b1;
        evt_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            @(negedge sys_clk);
            checks++;
            if (evt_valid !== 1'b0) begin
                errors++; $display("FAIL midrst_quiet cycle=%0d valid=%b expected 0", i, evt_valid);
            end
        end
        exp_q.push_back(W'(KEY_CONFIRM));
        pulse(6'b010000);
        wait_drain(10);
    endtask

    task automatic test_random_stall();
        int k;
        do_reset();
        for (int n = 0; n < 8; n++) begin
            k = $urandom_range(0, 4);
            exp_q.push_back(W'(k));
            evt_ready = 1'($urandom_range(0, 1));
            pulse(N'(1) << k);
            for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
                evt_ready = 1'($urandom_range(0, 1));
                tick();
            end
            evt_ready = 1'b1;
            wait_drain(20);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_cancel_flush();
        test_overrun();
        test_simultaneous();
        test_reset_mid();
        test_random_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
